// File: rtl/relu_pool_l1_pkg.sv
// Shared sizing and helpers for the layer-1 ReLU + 2x2 max-pool stage.
package relu_pool_l1_pkg;

    localparam int unsigned IMG_W  = 28;
    localparam int unsigned IMG_H  = 28;
    localparam int unsigned DATA_W = 16;

    // Region where the 3x3 window is complete, and the pooled grid over it
    localparam int unsigned VW = IMG_W - 2;
    localparam int unsigned VH = IMG_H - 2;
    localparam int unsigned PW = VW / 2;
    localparam int unsigned PH = VH / 2;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned IDX_W = $clog2(PW);

    // Unsigned max; operands are already non-negative after ReLU
    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_pool_l1_line_buf.sv
// One-row store of horizontal pair maxima, written on even pooled rows, read on odd.
module pool_line_buf
    import relu_pool_l1_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [PW];

    // Synchronous write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/relu_pool_l1.sv
// ReLU + 2x2/stride-2 max-pool over the valid region of the layer-1 conv stream.
module relu_pool_l1
    import relu_pool_l1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] conv_in,
    input  logic              in_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] pool_out,
    output logic              out_valid,
    output logic              frame_done
);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] hreg;

    logic [COL_W-1:0]  cur_col_c;
    logic [ROW_W-1:0]  cur_row_c;
    logic [COL_W-1:0]  vc_c;
    logic [ROW_W-1:0]  vr_c;
    logic [DATA_W-1:0] relu_c;
    logic [DATA_W-1:0] hmax_c;
    logic [DATA_W-1:0] lb_rdata_c;
    logic [IDX_W-1:0]  idx_c;
    logic              in_window_c;
    logic              pair_done_c;
    logic              lb_we_c;
    logic              emit_c;
    logic              last_c;

    // Beat position (sof forces origin), window qualification and pooling datapath
    always_comb begin
        cur_col_c   = sof ? '0 : col;
        cur_row_c   = sof ? '0 : row;
        vc_c        = cur_col_c - COL_W'(2);
        vr_c        = cur_row_c - ROW_W'(2);
        // Trailing odd row/column of the valid region is dropped entirely
        in_window_c = in_valid
                   && (cur_row_c >= ROW_W'(2)) && (cur_col_c >= COL_W'(2))
                   && (vr_c < ROW_W'(2 * PH)) && (vc_c < COL_W'(2 * PW));
        relu_c      = conv_in[DATA_W-1] ? '0 : conv_in;
        hmax_c      = max_u(hreg, relu_c);
        idx_c       = IDX_W'(vc_c >> 1);
        pair_done_c = in_window_c && vc_c[0];
        lb_we_c     = !reset && pair_done_c && !vr_c[0];
        emit_c      = pair_done_c && vr_c[0];
        last_c      = in_valid
                   && (cur_row_c == ROW_W'(IMG_H - 1))
                   && (cur_col_c == COL_W'(IMG_W - 1));
    end

    // Raster position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col_c == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row_c == ROW_W'(IMG_H - 1)) ? '0 : cur_row_c + ROW_W'(1);
            end else begin
                col <= cur_col_c + COL_W'(1);
                row <= cur_row_c;
            end
        end
    end

    // Left half of each horizontal pair
    always_ff @(posedge clk) begin
        if (reset) begin
            hreg <= '0;
        end else if (in_window_c && !vc_c[0]) begin
            hreg <= relu_c;
        end
    end

    // Pooled pixel strobe and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_out   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit_c;
            frame_done <= last_c;
            if (emit_c) begin
                pool_out <= max_u(lb_rdata_c, hmax_c);
            end
        end
    end

    pool_line_buf u_line_buf (
        .clk     (clk),
        .we      (lb_we_c),
        .waddr   (idx_c),
        .wdata   (hmax_c),
        .raddr   (idx_c),
        .rdata_c (lb_rdata_c)
    );

endmodule

// File: tb/tb_relu_pool_l1.sv
// Randomised bench for relu_pool_l1 against a frame-array pooling model.
module tb_relu_pool_l1;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int PW = (W - 2) / 2;
    localparam int PH = (H - 2) / 2;
    localparam int NP = PW * PH;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] conv_in;
    logic        in_valid;
    logic        sof;
    logic [15:0] pool_out;
    logic        out_valid;
    logic        frame_done;

    relu_pool_l1 dut (
        .clk        (clk),
        .reset      (reset),
        .conv_in    (conv_in),
        .in_valid   (in_valid),
        .sof        (sof),
        .pool_out   (pool_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: the current frame as a plain 2-D image plus raster position
    int img [H][W];
    int mr = 0;
    int mc = 0;
    int exp_po = 0;
    bit exp_ov = 1'b0;
    bit exp_fd = 1'b0;
    bit chk_en = 1'b0;

    int dut_q[$];
    int ov_cnt = 0;
    int fd_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
        return (v >= 32768) ? 0 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Per-cycle compare of all outputs against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("out_valid", int'(out_valid), int'(exp_ov));
                chk("frame_done", int'(frame_done), int'(exp_fd));
                chk("pool_out", int'(pool_out), exp_po);
                if (out_valid) begin
                    dut_q.push_back(int'(pool_out));
                    ov_cnt++;
                end
                if (frame_done) fd_cnt++;
            end
        end
    end

    // Drive one cycle and advance the model
    task automatic drive(input bit r, input bit v, input bit s, input int d);
        int vr;
        int vc;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        sof      = s;
        conv_in  = 16'(d);
        exp_ov   = 1'b0;
        exp_fd   = 1'b0;
        if (r) begin
            exp_po = 0;
            mr = 0;
            mc = 0;
        end else if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = d & 32'hFFFF;
            vr = mr - 2;
            vc = mc - 2;
            if (vr >= 0 && vc >= 0 && (vr % 2 == 1) && (vc % 2 == 1)
                && vr < 2 * PH && vc < 2 * PW) begin
                exp_po = max2(max2(relu(img[mr-1][mc-1]), relu(img[mr-1][mc])),
                              max2(relu(img[mr][mc-1]),   relu(img[mr][mc])));
                exp_ov = 1'b1;
            end
            exp_fd = (mr == H - 1) && (mc == W - 1);
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end
    endtask

    function automatic int pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 5;
            1:       return 32'h0000_FF9C;
            2:       return r * W + c;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    // Raster frame; idle gaps with junk data/sof at given percent; stops before (stop_r, stop_c)
    task automatic frame(input int mode, input int duty, input bit sof0,
                         input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                while (int'($urandom_range(0, 99)) < duty)
                    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom));
                drive(1'b0, 1'b1, sof0 && r == 0 && c == 0, pix(mode, r, c));
            end
        end
    endtask

    // Independent closed-form check of the ramp's pooled sequence
    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, dut_q.size(), NP);
        if (dut_q.size() >= NP) begin
            for (int i = 0; i < PH; i++)
                for (int j = 0; j < PW; j++)
                    chk({tag, "_val"}, dut_q[i*PW+j], (2*i+3)*W + (2*j+3));
            chk({tag, "_first"}, dut_q[0], 87);
            chk({tag, "_second"}, dut_q[1], 89);
            chk({tag, "_last"}, dut_q[NP-1], 783);
        end
    endtask

    task automatic clear_stats();
        dut_q.delete();
        ov_cnt = 0;
        fd_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sof = 1'b0; conv_in = '0;
        drive(1'b1, 1'b0, 1'b0, 0);
        chk_en = 1'b1;

        // 1: reset held with in_valid toggling
        for (int k = 0; k < 3; k++)
            drive(1'b1, 1'(k % 2), 1'($urandom_range(0, 1)), int'($urandom));

        // 2: constant 5
        clear_stats();
        frame(0, 0, 1'b1, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        chk("s2_strobes", ov_cnt, NP);
        chk("s2_frame_done", fd_cnt, 1);
        if (dut_q.size() > 0) chk("s2_value", dut_q[0], 5);

        // 3: constant -100 clamps to zero
        clear_stats();
        frame(1, 0, 1'b0, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        chk("s3_strobes", ov_cnt, NP);
        chk("s3_frame_done", fd_cnt, 1);
        if (dut_q.size() > 0) chk("s3_value", dut_q[NP/2 < dut_q.size() ? NP/2 : 0], 0);

        // 4: ramp, continuous
        clear_stats();
        frame(2, 0, 1'b1, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        check_ramp("s4");

        // 5: ramp, ~50% duty
        clear_stats();
        frame(2, 50, 1'b0, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        check_ramp("s5");

        // 6A: sof mid-frame at (10,5)
        frame(3, 0, 1'b1, 10, 5);
        clear_stats();
        frame(2, 0, 1'b1, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        check_ramp("s6a");

        // 6B: reset at (15,0), then fresh frame without sof
        frame(3, 20, 1'b1, 15, 0);
        drive(1'b1, 1'b1, 1'b0, int'($urandom));
        clear_stats();
        frame(2, 20, 1'b0, -1, -1);
        drive(1'b0, 1'b0, 1'b0, 0);
        check_ramp("s6b");
        chk("s6b_frame_done", fd_cnt, 1);

        // Random data frames with random gaps
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            frame(3, 30, 1'b0, -1, -1);
            drive(1'b0, 1'b0, 1'b0, 0);
            chk("rand_strobes", ov_cnt, NP);
            chk("rand_frame_done", fd_cnt, 1);
        end

        drive(1'b0, 1'b0, 1'b0, 0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
